// File: rtl/aib_pattern_gen_chk.sv
`timescale 1ns/1ps
// AIB link pattern generator and self-synchronising checker.
// The generator emits PRBS7, PRBS15 or counter words. The checker seeds from
// received data, counts compared and mismatched words, and tracks lock.
module aib_pattern_gen_chk #(
    parameter int DATAWIDTH   = 20,
    parameter int LOCK_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             cfg_mode,
    input  logic                   cfg_ddr,
    input  logic [CNT_W-1:0]       cfg_num_words,
    input  logic                   gen_en,
    input  logic                   inj_err,
    output logic [2*DATAWIDTH-1:0] tx_data,
    output logic                   tx_valid,
    input  logic                   chk_en,
    input  logic [2*DATAWIDTH-1:0] rx_data,
    input  logic                   rx_valid,
    output logic [1:0]             chk_state,
    output logic                   lost_lock,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       word_cnt,
    output logic                   chk_done
);

    localparam int          W2     = 2 * DATAWIDTH;
    localparam int unsigned W2U    = W2;
    localparam int unsigned DWU    = DATAWIDTH;
    localparam logic [3:0]  THRESH = 4'(LOCK_THRESH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEED   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // One word of PRBS from a bit-history state. s[0] is the oldest bit (b[n-7] or
    // b[n-15]) and the newest bit lands at the top of the active history.
    function automatic logic [W2-1:0] prbs_word(input logic [14:0] st, input logic p15,
                                                 input logic ddr);
        logic [14:0]   s;
        logic          nb;
        logic [W2-1:0] w;
        s  = st;
        nb = 1'b0;
        w  = '0;
        for (int unsigned i = 0; i < W2U; i++) begin
            if (ddr || (i < DWU)) begin
                nb   = s[0] ^ s[1];
                w[i] = nb;
                s    = p15 ? {nb, s[14:1]} : {8'b0, nb, s[6:1]};
            end
        end
        return w;
    endfunction

    // The last 7/15 bits of a word are exactly the history state that produced
    // the next word, so generator and checker both reseed from the word top.
    function automatic logic [14:0] top_bits(input logic [W2-1:0] w, input logic p15,
                                             input logic ddr);
        logic [14:0] t;
        t = ddr ? w[W2-1 -: 15] : w[DATAWIDTH-1 -: 15];
        return p15 ? t : {8'b0, t[14:8]};
    endfunction

    logic          w_p15;
    logic          w_cnt_mode;
    logic [W2-1:0] w_mask;
    logic [W2-1:0] w_gen_word;
    logic [W2-1:0] w_rx;
    logic [W2-1:0] w_exp;
    logic          w_mis;
    logic [CNT_W-1:0] w_words_nx;
    logic [CNT_W-1:0] w_err_nx;
    logic [3:0]    w_consec_nx;
    logic          w_done_hit;
    logic          w_lock_loss;

    logic [14:0]   r_gen_st;
    logic [W2-1:0] r_gen_cnt;
    logic [W2-1:0] r_tx_data;
    logic          r_tx_valid;
    logic [1:0]    r_state;
    logic [W2-1:0] r_last;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_words;
    logic          r_lost;
    logic [3:0]    r_consec;

    assign w_p15      = (cfg_mode == 2'd1);
    assign w_cnt_mode = (cfg_mode == 2'd2);
    assign w_mask     = cfg_ddr ? {W2{1'b1}} : {{DATAWIDTH{1'b0}}, {DATAWIDTH{1'b1}}};

    assign w_gen_word = w_cnt_mode ? ((r_gen_cnt + 1'b1) & w_mask)
                                   : prbs_word(r_gen_st, w_p15, cfg_ddr);

    assign w_rx  = rx_data & w_mask;
    assign w_exp = w_cnt_mode ? ((r_last + 1'b1) & w_mask)
                              : prbs_word(top_bits(r_last, w_p15, cfg_ddr), w_p15, cfg_ddr);
    assign w_mis = (w_rx != w_exp);

    assign w_words_nx  = (r_words == '1) ? r_words : r_words + 1'b1;
    assign w_err_nx    = (r_err == '1) ? r_err : r_err + 1'b1;
    assign w_consec_nx = r_consec + 4'd1;
    assign w_done_hit  = (cfg_num_words != '0) && (w_words_nx == cfg_num_words);
    assign w_lock_loss = w_mis && (w_consec_nx == THRESH);

    // Generator: registered word per enabled cycle, restart from initial state when disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gen_st   <= '1;
            r_gen_cnt  <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (gen_en) begin
            r_tx_data  <= w_gen_word ^ {{(W2-1){1'b0}}, inj_err};
            r_tx_valid <= 1'b1;
            if (w_cnt_mode) begin
                r_gen_cnt <= w_gen_word;
            end else begin
                r_gen_st <= top_bits(w_gen_word, w_p15, cfg_ddr);
            end
        end else begin
            r_gen_st   <= '1;
            r_gen_cnt  <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end
    end

    // Checker state machine and counters; expectation always reseeds from the received word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_last   <= '0;
            r_err    <= '0;
            r_words  <= '0;
            r_lost   <= 1'b0;
            r_consec <= '0;
        end else if (!chk_en) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_SEED;
                    r_err    <= '0;
                    r_words  <= '0;
                    r_lost   <= 1'b0;
                    r_consec <= '0;
                end
                ST_SEED: begin
                    if (rx_valid) begin
                        r_last   <= w_rx;
                        r_consec <= '0;
                        r_state  <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (rx_valid) begin
                        r_last  <= w_rx;
                        r_words <= w_words_nx;
                        if (w_mis) begin
                            r_err <= w_err_nx;
                        end
                        if (w_lock_loss) begin
                            r_lost <= 1'b1;
                        end
                        r_consec <= (w_mis && !w_lock_loss) ? w_consec_nx : 4'd0;
                        if (w_done_hit) begin
                            r_state <= ST_DONE;
                        end else if (w_lock_loss) begin
                            r_state <= ST_SEED;
                        end
                    end
                end
                default: r_state <= ST_DONE;
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign chk_state = r_state;
    assign lost_lock = r_lost;
    assign err_cnt   = r_err;
    assign word_cnt  = r_words;
    assign chk_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_aib_pattern_gen_chk.sv
`timescale 1ns/1ps
// Scoreboard bench for aib_pattern_gen_chk: generated words and checker
// completion results are queued by the stimulus and consumed by monitors.
module tb_aib_pattern_gen_chk;

    localparam int DW = 20;
    localparam int W2 = 40;
    localparam int CW = 4;

    typedef struct {
        logic [CW-1:0] err;
        logic [CW-1:0] words;
        logic          lost;
    } done_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic          cfg_ddr = 1'b1;
    logic [CW-1:0] cfg_num_words = '0;
    logic          gen_en = 1'b0;
    logic          inj_err = 1'b0;
    logic          chk_en = 1'b0;
    logic [W2-1:0] tx_data;
    logic          tx_valid;
    logic [W2-1:0] rx_data;
    logic          rx_valid;
    logic [1:0]    chk_state;
    logic          lost_lock;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] word_cnt;
    logic          chk_done;

    logic          loop_en = 1'b1;
    logic [W2-1:0] rx_drv = '0;
    logic          rx_vdrv = 1'b0;
    logic [W2-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic          v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [W2-1:0] tx_q[$];
    done_t         done_q[$];
    logic          prev_done = 1'b0;
    logic          saw_seed_lost = 1'b0;

    logic [14:0]   mh;
    logic [W2-1:0] mc;

    aib_pattern_gen_chk #(
        .DATAWIDTH   (DW),
        .LOCK_THRESH (4),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_mode      (cfg_mode),
        .cfg_ddr       (cfg_ddr),
        .cfg_num_words (cfg_num_words),
        .gen_en        (gen_en),
        .inj_err       (inj_err),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .chk_en        (chk_en),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .chk_state     (chk_state),
        .lost_lock     (lost_lock),
        .err_cnt       (err_cnt),
        .word_cnt      (word_cnt),
        .chk_done      (chk_done)
    );

    always #5 clk = ~clk;

    // 3-cycle loopback from tx to rx
    always @(posedge clk) begin
        d1 <= tx_data;  v1 <= tx_valid;
        d2 <= d1;       v2 <= v1;
        d3 <= d2;       v3 <= v2;
    end
    assign rx_data  = loop_en ? d3 : rx_drv;
    assign rx_valid = loop_en ? v3 : rx_vdrv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference: mh[0] is the most recent bit.
    task automatic model_reset();
        mh = '1;
        mc = '0;
    endtask

    task automatic model_word(output logic [W2-1:0] w);
        int   aw;
        logic nb;
        aw = cfg_ddr ? W2 : DW;
        w  = '0;
        if (cfg_mode == 2'd2) begin
            mc = mc + 1'b1;
            if (!cfg_ddr) mc[W2-1:DW] = '0;
            w = mc;
        end else begin
            for (int i = 0; i < aw; i++) begin
                nb   = (cfg_mode == 2'd1) ? (mh[14] ^ mh[13]) : (mh[6] ^ mh[5]);
                w[i] = nb;
                mh   = {mh[13:0], nb};
            end
        end
    endtask

    // tx monitor
    always @(negedge clk) begin
        logic [W2-1:0] w;
        if (tx_valid) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_unexpected: got 0x%0h expected no word at %0t", tx_data, $time);
            end else begin
                w = tx_q.pop_front();
                check("tx_word", tx_data, w);
            end
        end else begin
            check("tx_idle_zero", tx_data, 0);
        end
    end

    // checker completion monitor
    always @(negedge clk) begin
        done_t e;
        if (chk_done && !prev_done) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_unexpected: got done expected none at %0t", $time);
            end else begin
                e = done_q.pop_front();
                check("done_err_cnt", err_cnt, e.err);
                check("done_word_cnt", word_cnt, e.words);
                check("done_lost_lock", lost_lock, e.lost);
            end
        end
        prev_done = chk_done;
        if (lost_lock && chk_state == 2'd1) saw_seed_lost = 1'b1;
    end

    task automatic run_gen(input int n, input logic [63:0] inj_mask, input bit hand_chk);
        logic [W2-1:0] w;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hand_chk && i == 1) check("prbs7_first_word_lo", tx_data[19:0], 20'h43040);
            gen_en  = 1'b1;
            inj_err = inj_mask[i];
            model_word(w);
            if (inj_mask[i]) w[0] = ~w[0];
            tx_q.push_back(w);
        end
        @(negedge clk);
        gen_en  = 1'b0;
        inj_err = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!chk_done && c < 40) begin
            @(negedge clk);
            c++;
        end
        check(name, chk_done, 1);
        @(negedge clk);
    endtask

    task automatic end_scn();
        @(negedge clk);
        chk_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [W2:0]   vec[7];
        logic [63:0]   mask;
        logic [W2-1:0] w;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_state", chk_state, 0);
        check("rst_lost", lost_lock, 0);
        check("rst_err", err_cnt, 0);
        check("rst_words", word_cnt, 0);
        check("rst_done", chk_done, 0);
        @(negedge clk);
        rstn = 1'b1;

        // PRBS7 DDR loopback, 10 words to done
        cfg_mode = 2'd0; cfg_ddr = 1'b1; cfg_num_words = 4'd10;
        done_q.push_back('{err: 4'd0, words: 4'd10, lost: 1'b0});
        @(negedge clk);
        chk_en = 1'b1;
        run_gen(14, 64'h0, 1'b1);
        wait_done("s1_reached_done");
        check("s1_state_done", chk_state, 3);
        end_scn();

        // same with one injected error on the 5th word
        done_q.push_back('{err: 4'd1, words: 4'd10, lost: 1'b0});
        chk_en = 1'b1;
        run_gen(14, 64'h10, 1'b0);
        wait_done("s2_reached_done");
        check("s2_lost_lock", lost_lock, 0);
        end_scn();

        // four consecutive corrupted words -> lock loss and relock
        cfg_num_words = 4'd0;
        saw_seed_lost = 1'b0;
        chk_en = 1'b1;
        run_gen(12, 64'h78, 1'b0);
        repeat (6) @(negedge clk);
        check("s3_saw_seed_lost", saw_seed_lost, 1);
        check("s3_lost_lock", lost_lock, 1);
        check("s3_err", err_cnt, 4);
        check("s3_words", word_cnt, 10);
        check("s3_relocked", chk_state, 2);
        end_scn();

        // counter mode SDR loopback
        cfg_mode = 2'd2; cfg_ddr = 1'b0; cfg_num_words = 4'd0;
        chk_en = 1'b1;
        run_gen(8, 64'h0, 1'b0);
        repeat (6) @(negedge clk);
        check("s4_err", err_cnt, 0);
        check("s4_words", word_cnt, 7);
        check("s4_state", chk_state, 2);
        end_scn();

        // counter wrap with gaps and garbage above the active width
        loop_en = 1'b0;
        cfg_num_words = 4'd3;
        done_q.push_back('{err: 4'd0, words: 4'd3, lost: 1'b0});
        vec[0] = {1'b1, 40'hA5A5A_FFFFE};
        vec[1] = {1'b0, 40'h12345_00007};
        vec[2] = {1'b1, 40'h3C3C3_FFFFF};
        vec[3] = {1'b1, 40'hFFFFF_00000};
        vec[4] = {1'b0, 40'h00000_00000};
        vec[5] = {1'b1, 40'h00001_00001};
        vec[6] = {1'b1, 40'h00000_12345};
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rx_vdrv = vec[i][W2];
            rx_drv  = vec[i][W2-1:0];
        end
        @(negedge clk);
        rx_vdrv = 1'b0;
        wait_done("s4w_reached_done");
        check("s4w_words_held", word_cnt, 3);
        check("s4w_err_held", err_cnt, 0);
        end_scn();
        loop_en = 1'b1;

        // PRBS15 DDR with 20 isolated errors: counters saturate
        cfg_mode = 2'd1; cfg_ddr = 1'b1; cfg_num_words = 4'd0;
        mask = '0;
        for (int i = 0; i < 60; i++) if (i % 3 == 1) mask[i] = 1'b1;
        chk_en = 1'b1;
        run_gen(62, mask, 1'b0);
        repeat (6) @(negedge clk);
        check("s5_err_sat", err_cnt, 15);
        check("s5_words_sat", word_cnt, 15);
        check("s5_lost_lock", lost_lock, 0);
        end_scn();

        // asynchronous reset while locked
        cfg_mode = 2'd0; cfg_ddr = 1'b1; cfg_num_words = 4'd0;
        chk_en = 1'b1;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            gen_en  = 1'b1;
            inj_err = (i == 2 || i == 5 || i == 8);
            model_word(w);
            if (inj_err) w[0] = ~w[0];
            if (i < 14) tx_q.push_back(w);
        end
        @(posedge clk);
        #2;
        check("s6_pre_err", err_cnt, 3);
        check("s6_pre_state", chk_state, 2);
        rstn = 1'b0;
        gen_en = 1'b0; chk_en = 1'b0; inj_err = 1'b0;
        #1;
        check("s6_tx_data", tx_data, 0);
        check("s6_tx_valid", tx_valid, 0);
        check("s6_state", chk_state, 0);
        check("s6_lost", lost_lock, 0);
        check("s6_err", err_cnt, 0);
        check("s6_words", word_cnt, 0);
        check("s6_done", chk_done, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        check("tx_queue_drained", tx_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
